universal_reg: RTL

Parametrised multi-mode register bank. It generalises the single-bit master-slave D flip-flop to WIDTH bits and adds the following modes, all selected per cycle:

- hold
- parallel load
- T-style toggle
- logical shifts with serial inputs
- rotates
- synchronous clear

It is the team's standard building block for datapath registers, shift chains and counters-by-composition. All state changes on the rising edge of `clk`, with an asynchronous override from `rst`.

---
 rtl/universal_reg.sv | 67 ++++++
 1 files changed

// File: rtl/universal_reg.sv
// Multi-mode WIDTH-bit register: hold, load, shift, rotate, toggle and sync clear.
// Latency: one clk edge from inputs to q; changed is registered alongside q.
// Backpressure: none; accepts one operation every cycle, en=0 stalls in place.
module universal_reg #(
    parameter int                 WIDTH       = 8,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             zero,
    output logic             changed
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_TOG  = 3'b110,
        MODE_CLR  = 3'b111
    } mode_e;

    logic [WIDTH-1:0] q_nxt;

    always_comb begin
        q_nxt = q;
        if (en) begin
            case (mode_e'(mode))
                MODE_HOLD: q_nxt = q;
                MODE_LOAD: q_nxt = d;
                MODE_SHL:  q_nxt = {q[WIDTH-2:0], sin_l};
                MODE_SHR:  q_nxt = {sin_r, q[WIDTH-1:1]};
                MODE_ROL:  q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
                MODE_ROR:  q_nxt = {q[0], q[WIDTH-1:1]};
                MODE_TOG:  q_nxt = q ^ d;
                MODE_CLR:  q_nxt = '0;
                default:   q_nxt = q;
            endcase
        end
    end

    // changed compares against the old q, so no-op loads/rotates report 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q       <= RESET_VALUE;
            changed <= 1'b0;
        end else begin
            q       <= q_nxt;
            changed <= (q_nxt != q);
        end
    end

    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];
    assign zero   = (q == '0);

endmodule
